// File: rtl/qspi_sram_controller_if.sv
// Request/response bundle between the engine memory port and the QSPI controller.
// The master issues single-byte requests; the slave answers with done/rdata.
interface qspi_sram_controller_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [23:0] req_addr;
   logic [7:0]  req_wdata;
   logic        done;
   logic [7:0]  rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, done, rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, done, rdata
   );
endinterface

// File: rtl/qspi_sram_controller.sv
// SQI-mode initiator for single-byte reads/writes to the PMOD QSPI SRAM.
// Each nibble spans two clk cycles: sck low (drive) then sck high (sample).
module qspi_sram_controller #(
   parameter int DUMMY_NIBBLES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   qspi_sram_controller_if.slave        bus,
   output logic                         o_sck,
   output logic                         o_ss_n,
   output logic [3:0]                   o_sio_out,
   output logic [3:0]                   o_sio_oe,
   input  logic [3:0]                   i_sio_in
);

   localparam logic [7:0] READ_CMD   = 8'h03;
   localparam logic [7:0] WRITE_CMD  = 8'h02;
   localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_DESEL
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nx;
   logic        r_ph;
   logic        w_ph_nx;
   logic        r_we;
   logic [39:0] r_sh;
   logic [3:0]  r_rhi;
   logic [7:0]  r_rdata;
   logic        w_accept;
   logic        w_nib_end;
   logic        w_last;
   logic        w_drive;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_ph    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_ph    <= w_ph_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_ph_nx       = 1'b0;
      w_accept      = 1'b0;
      w_nib_end     = 1'b0;
      w_last        = 1'b0;
      w_drive       = 1'b0;
      bus.req_ready = 1'b0;
      bus.done      = 1'b0;
      o_sck         = 1'b0;
      o_ss_n        = 1'b1;
      o_sio_out     = 4'h0;
      o_sio_oe      = 4'h0;

      unique case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               w_accept   = 1'b1;
               w_state_nx = S_CMD;
               w_cnt_nx   = 3'd0;
            end
         end
         S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
            o_ss_n    = 1'b0;
            o_sck     = r_ph;
            w_ph_nx   = ~r_ph;
            w_nib_end = r_ph;
            w_drive   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        ((r_state == S_DATA) && r_we);
            if (w_drive) begin
               o_sio_oe  = 4'hF;
               o_sio_out = r_sh[39:36];
            end

            unique case (r_state)
               S_CMD:   w_last = (r_cnt == 3'd1);
               S_ADDR:  w_last = (r_cnt == 3'd5);
               S_DUMMY: w_last = (r_cnt == DUMMY_LAST);
               default: w_last = (r_cnt == 3'd1);
            endcase

            if (w_nib_end) begin
               w_cnt_nx = r_cnt + 3'd1;
               if (w_last) begin
                  w_cnt_nx = 3'd0;
                  unique case (r_state)
                     S_CMD:   w_state_nx = S_ADDR;
                     S_ADDR:  w_state_nx = (r_we || DUMMY_NIBBLES == 0) ?
                                            S_DATA : S_DUMMY;
                     S_DUMMY: w_state_nx = S_DATA;
                     default: w_state_nx = S_DESEL;
                  endcase
               end
            end
         end
         S_DESEL: begin
            bus.done   = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Outgoing nibbles shift out of the top; dummy nibbles leave it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_sh    <= 40'h0;
         r_rhi   <= 4'h0;
         r_rdata <= 8'h00;
      end else begin
         if (w_accept) begin
            r_we <= bus.req_we;
            r_sh <= {(bus.req_we ? WRITE_CMD : READ_CMD),
                     bus.req_addr, bus.req_wdata};
         end else if (w_nib_end && r_state != S_DUMMY) begin
            r_sh <= {r_sh[35:0], 4'h0};
         end

         if (w_nib_end && r_state == S_DATA && !r_we) begin
            if (r_cnt == 3'd0)
               r_rhi <= i_sio_in;
            else
               r_rdata <= {r_rhi, i_sio_in};
         end
      end
   end

   assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_qspi_sram_controller.sv
// Scoreboard bench for qspi_sram_controller with a behavioural SQI SRAM responder.
// Driver pushes expected transactions; a done-triggered monitor pops and compares.
module tb_qspi_sram_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck;
   logic       ss_n;
   logic [3:0] sio_out;
   logic [3:0] sio_oe;
   logic [3:0] sio_in = 4'h0;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         viol = 0;

   qspi_sram_controller_if bus ();

   qspi_sram_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .o_sck     (sck),
      .o_ss_n    (ss_n),
      .o_sio_out (sio_out),
      .o_sio_oe  (sio_oe),
      .i_sio_in  (sio_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [47:0] nibs;
      int          cnt;
      logic [11:0] oe;
      int          lat;
      logic [7:0]  rd;
      int          tacc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [47:0] act,
                      input logic [47:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SQI SRAM responder
   logic [7:0] mem [logic [23:0]];
   int         rn = 0;
   logic [39:0] rsh = 40'h0;
   logic [7:0] rcmd = 8'h00;
   logic [23:0] raddr = 24'h0;

   function automatic logic [7:0] rd_mem(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   always @(posedge sck or posedge ss_n) begin
      if (ss_n) begin
         rn = 0;
      end else begin
         rsh = {rsh[35:0], sio_out};
         rn++;
         if (rn == 8) begin
            rcmd  = rsh[31:24];
            raddr = rsh[23:0];
         end
         if (rn == 10 && rcmd == 8'h02)
            mem[raddr] = rsh[7:0];
      end
   end

   always @(negedge sck) begin
      if (!ss_n && rcmd == 8'h03) begin
         if (rn == 10) sio_in = rd_mem(raddr) >> 4;
         else if (rn == 11) sio_in = rd_mem(raddr) & 8'h0F;
      end
   end

   // Bus-side capture of every nibble the DUT presents at an sck rise
   logic [47:0] mon_nibs = 48'h0;
   logic [11:0] mon_oe = 12'h0;
   int          mon_cnt = 0;

   always @(posedge sck or negedge ss_n) begin
      if (!ss_n && sck) begin
         mon_nibs = {mon_nibs[43:0], sio_out};
         mon_oe   = {mon_oe[10:0], &sio_oe};
         mon_cnt++;
      end else begin
         mon_nibs = 48'h0;
         mon_oe   = 12'h0;
         mon_cnt  = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 48'h1, 48'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sck_rises", 48'(mon_cnt), 48'(e.cnt));
            chk("nibbles", mon_nibs, e.nibs);
            chk("oe_per_nibble", 48'(mon_oe), 48'(e.oe));
            chk("done_latency", 48'(cyc - e.tacc), 48'(e.lat));
            if (!e.we) chk("rdata", 48'(bus.rdata), 48'(e.rd));
         end
      end
   end

   // Protocol invariants sampled every cycle
   logic       p_done = 1'b0;
   logic       p_ss = 1'b1;
   logic [3:0] p_oe = 4'h0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (sck && ss_n) viol++;
         if (bus.done && bus.req_ready) viol++;
         if (bus.done && p_done) viol++;
         if (sck && sio_oe != p_oe) viol++;
         if (ss_n != p_ss && sck) viol++;
         if (sio_oe != 4'h0 && sio_oe != 4'hF) viol++;
      end
      p_done = bus.done;
      p_ss   = ss_n;
      p_oe   = sio_oe;
   end

   task automatic issue(input logic we, input logic [23:0] a,
                        input logic [7:0] d, input logic [47:0] nibs,
                        input logic [7:0] rd, input bit hold,
                        output int tacc);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      for (int i = 0; i < 200; i++) begin
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      tacc = cyc;
      if (!ok) begin
         chk("accept_timeout", 48'h0, 48'h1);
      end else begin
         e.we   = we;
         e.nibs = nibs;
         e.cnt  = we ? 10 : 12;
         e.oe   = we ? 12'h3FF : 12'hFF0;
         e.lat  = we ? 21 : 25;
         e.rd   = rd;
         e.tacc = tacc;
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      bus.req_addr  = ~a;
      bus.req_wdata = ~d;
      bus.req_we    = ~we;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("idle_timeout", 48'h0, 48'h1);
         sb.delete();
      end
   endtask

   int t0;
   int t1;

   initial begin
      mem[24'h000010] = 8'h3C;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 24'h0;
      bus.req_wdata = 8'h0;

      repeat (3) @(negedge clk);
      chk("rst_ss_n", 48'(ss_n), 48'h1);
      chk("rst_sck", 48'(sck), 48'h0);
      chk("rst_sio_oe", 48'(sio_oe), 48'h0);
      chk("rst_req_ready", 48'(bus.req_ready), 48'h1);
      chk("rst_done", 48'(bus.done), 48'h0);
      chk("rst_rdata", 48'(bus.rdata), 48'h0);
      rst_n = 1'b1;

      issue(1'b1, 24'h012345, 8'hA5, 48'h0002012345A5, 8'h00, 1'b0, t0);
      wait_idle();
      issue(1'b0, 24'h000010, 8'h00, 48'h030000100000, 8'h3C, 1'b0, t0);
      wait_idle();

      issue(1'b1, 24'hFFFFFF, 8'hFF, 48'h0002FFFFFFFF, 8'h00, 1'b0, t0);
      wait_idle();
      issue(1'b0, 24'hFFFFFF, 8'h00, 48'h03FFFFFF0000, 8'hFF, 1'b0, t0);
      wait_idle();

      issue(1'b0, 24'h012345, 8'h00, 48'h030123450000, 8'hA5, 1'b1, t0);
      issue(1'b1, 24'h000020, 8'h5A, 48'h00020000205A, 8'h00, 1'b0, t1);
      chk("b2b_accept_gap", 48'(t1 - t0), 48'd26);
      wait_idle();
      issue(1'b0, 24'h000020, 8'h00, 48'h030000200000, 8'h5A, 1'b0, t0);
      wait_idle();

      issue(1'b1, 24'h000030, 8'h77, 48'h000200003077, 8'h00, 1'b0, t0);
      for (int i = 0; i < 20 && cyc < t0 + 7; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ss_n", 48'(ss_n), 48'h1);
      chk("abort_sck", 48'(sck), 48'h0);
      chk("abort_sio_oe", 48'(sio_oe), 48'h0);
      chk("abort_req_ready", 48'(bus.req_ready), 48'h1);
      chk("abort_rdata", 48'(bus.rdata), 48'h0);
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(1'b0, 24'h000030, 8'h00, 48'h030000300000, 8'h00, 1'b0, t0);
      wait_idle();
      issue(1'b0, 24'h000010, 8'h00, 48'h030000100000, 8'h3C, 1'b0, t0);
      wait_idle();

      chk("protocol_violations", 48'(viol), 48'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
